// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer:
// ALU_control codes, FSM state encoding, op classification helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [3:0] c);
        return (c == ALU_ADD) || (c == ALU_SUB) || (c == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/sum.
// Ports: a, b, invertA, invertB, carryIn, operation[1:0] -> result, carryOut.
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       invertA,
    input  logic       invertB,
    input  logic       carryIn,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carryOut
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a      = a ^ invertA;
    assign w_b      = b ^ invertB;
    assign w_sum    = w_a ^ w_b ^ carryIn;
    assign carryOut = (w_a & w_b) | (carryIn & (w_a ^ w_b));

    // Operation 11 yields the raw sum; the controller builds the SLT bit.
    always_comb begin
        result = 1'b0;
        unique case (operation)
            2'b00:        result = w_a & w_b;
            2'b01:        result = w_a | w_b;
            2'b10, 2'b11: result = w_sum;
            default:      result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one shared slice, one result bit per cycle, start/done.
// Ports: clk, rst_n, start, ALU_control, src1, src2 -> busy, done,
//        result, zero, cout, overflow (outputs held until the next done).
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [3:0]       r_ctrl;
    logic             r_cin_msb;
    logic             r_cout_msb;
    logic             r_sum_msb;

    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic             w_bit;
    logic             w_cout;
    logic             w_ovf;
    logic             w_arith;
    logic [WIDTH-1:0] w_final;

    alu_bit_slice u_slice (
        .a         (r_a_sr[0]),
        .b         (r_b_sr[0]),
        .invertA   (r_ctrl[3]),
        .invertB   (r_ctrl[2]),
        .carryIn   (r_carry),
        .operation (r_ctrl[1:0]),
        .result    (w_bit),
        .carryOut  (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == S_IDLE) && start;
        w_last   = (r_state == S_RUN) && (r_cnt == LAST);
        w_load   = (r_state == S_DONE);
    end

    // Operands shift right so the slice always sees bit 0; result bits
    // enter at the MSB and reach their final position after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_res_sr   <= '0;
            r_ctrl     <= '0;
            r_cin_msb  <= 1'b0;
            r_cout_msb <= 1'b0;
            r_sum_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= src1;
            r_b_sr  <= src2;
            r_ctrl  <= ALU_control;
            r_carry <= ALU_control[2];
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= {w_bit, r_res_sr[WIDTH-1:1]};
            r_carry  <= w_cout;
            if (w_last) begin
                r_cnt      <= '0;
                r_cin_msb  <= r_carry;
                r_cout_msb <= w_cout;
                r_sum_msb  <= w_bit;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_ovf   = r_cin_msb ^ r_cout_msb;
        w_arith = is_arith(r_ctrl);
        w_final = '0;
        case (r_ctrl)
            ALU_AND, ALU_OR, ALU_ADD,
            ALU_SUB, ALU_NOR, ALU_NAND: w_final = r_res_sr;
            // Sign of the true difference, corrected for overflow.
            ALU_SLT: w_final = {{(WIDTH-1){1'b0}}, r_sum_msb ^ w_ovf};
            default: w_final = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (w_next != S_IDLE);
            done <= w_load;
            if (w_load) begin
                result   <= w_final;
                zero     <= (w_final == '0);
                cout     <= w_arith & r_cout_msb;
                overflow <= w_arith & w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=32): arithmetic, logic,
// SLT, ignored starts, mid-run reset.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        z;
        logic        co;
        logic        ov;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    ALU_control = 4'b0;
    logic [W-1:0]  src1 = '0;
    logic [W-1:0]  src2 = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          zero;
    logic          cout;
    logic          overflow;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_done = 0;
    exp_t sb[$];

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_control (ALU_control),
        .src1        (src1),
        .src2        (src2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input string tag, input logic [3:0] c,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        e.tag = tag;
        e.res = '0;
        e.co  = 1'b0;
        e.ov  = 1'b0;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b1101: e.res = ~(a & b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.co  = s[32];
                e.ov  = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.co = s[32];
                e.ov = (a[31] != b[31]) && (s[31] != a[31]);
                if (c == 4'b0111)
                    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else
                    e.res = s[31:0];
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_res"}, result, e.res);
                    check({e.tag, "_zero"}, zero, e.z);
                    check({e.tag, "_cout"}, cout, e.co);
                    check({e.tag, "_ovf"}, overflow, e.ov);
                end
            end
        end
    end

    task automatic run_op(input string tag, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        int base;
        int lat;
        @(negedge clk);
        ALU_control = c;
        src1 = a;
        src2 = b;
        start = 1'b1;
        sb.push_back(model(tag, c, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        ALU_control = 4'($urandom);
        check({tag, "_busy"}, busy, 1);
        base = n_done;
        lat = 0;
        while (n_done == base && lat < 100) begin
            @(posedge clk);
            #2;
            lat++;
        end
        check({tag, "_lat"}, lat, 33);
        @(posedge clk);
        #2;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", result, 0);
        check("rst_flags", {zero, cout, overflow}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op("sub_eq",  4'b0110, 32'd5, 32'd5);
        run_op("sub_neg", 4'b0110, 32'd3, 32'd5);
        run_op("slt_ovf", 4'b0111, 32'h8000_0000, 32'h0000_0001);
        run_op("slt_gt",  4'b0111, 32'd5, 32'd3);
        run_op("slt_mx",  4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op("and",     4'b0000, 32'hFFFF_0000, 32'h00FF_FF00);
        run_op("nand",    4'b1101, 32'hFFFF_0000, 32'h00FF_FF00);
        run_op("or",      4'b0001, 32'hFFFF_0000, 32'h00FF_FF00);
        run_op("nor",     4'b1100, 32'hFFFF_0000, 32'h00FF_FF00);
        run_op("badcode", 4'b0011, 32'h1234_5678, 32'h0F0F_0F0F);

        // Starts during RUN and DONE must be dropped.
        n0 = n_done;
        @(negedge clk);
        ALU_control = 4'b0110;
        src1 = 32'h100;
        src2 = 32'h1;
        start = 1'b1;
        sb.push_back(model("ign", 4'b0110, 32'h100, 32'h1));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        ALU_control = 4'b0010;
        src1 = 32'h1;
        src2 = 32'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("ign_done_cnt", n_done - n0, 1);
        check("ign_busy", busy, 0);

        // Reset in the middle of RUN aborts the operation.
        n0 = n_done;
        @(negedge clk);
        ALU_control = 4'b0010;
        src1 = 32'h1234;
        src2 = 32'h1;
        start = 1'b1;
        sb.push_back(model("abort", 4'b0010, 32'h1234, 32'h1));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_res", result, 0);
        check("mrst_flags", {zero, cout, overflow}, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("mrst_no_done", n_done - n0, 0);

        run_op("add_post", 4'b0010, 32'd2, 32'd3);

        repeat (5) @(posedge clk);
        check("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
